uart_tx_stim: RTL and testbench

- Synthesizable 8N1 UART serializer (optional parity, 1/2 stop bits) with a small input FIFO.
- Drives the pulpino_top uart_rx pin in place of hand-toggled line stimulus.
- Upstream stage of the SoC UART receiver. Accepts bytes over a valid/ready handshake and emits them LSB-first at CLK_DIV clocks per bit.
- Lets testbenches and FPGA harnesses stream arbitrary byte sequences to the core.

---
 rtl/uart_tx_stim.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_stim.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stim.sv
// UART serializer stimulus source: bytes enter a small FIFO over valid/ready and
// leave as LSB-first frames (start, 8 data, optional parity, 1 or 2 stops).
module uart_tx_stim #(
    parameter int CLK_DIV    = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          uart_tx_o,
    output logic                          busy_o,
    output logic                          byte_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLK_DIV - 2);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic push, pop, bit_end;

    // Readiness comes from the registered level only, so a full FIFO never
    // accepts in the same cycle it pops.
    assign ready_o = !rst && (level_q != LW'(FIFO_DEPTH));
    assign push    = valid_i && ready_o;
    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        baud_d  = (state_q == S_IDLE || bit_end) ? '0 : baud_q + BW'(1);

        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) pop = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                // Pulse is registered, so it is raised one cycle early to land on the final stop cycle.
                if (bit_q == STOP_LAST && baud_q == BAUD_PRE) done_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        if (level_q != '0) pop = 1'b1;
                        else state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            state_d = S_START;
            shift_d = mem_q[rd_ptr_q];
            par_d   = (^mem_q[rd_ptr_q]) ^ 1'(PARITY_ODD);
            baud_d  = '0;
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);

        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE) || (level_d != '0);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: FIFO storage has no reset; the cleared level/pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    assign uart_tx_o    = tx_q;
    assign busy_o       = busy_q;
    assign byte_done_o  = done_q;
    assign fifo_level_o = level_q;

endmodule

// File: tb/tb_uart_tx_stim.sv
// Directed bench for uart_tx_stim: four instances cover default 8N1, even parity,
// odd parity and two stop bits; expected frames are built from the byte values.
module tb_uart_tx_stim;

    localparam int DIV = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] data;
    logic [3:0] valid;
    wire  [3:0] ready, tx, busy, done;
    wire  [2:0] lvl [4];

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] bb [4] = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
    logic [7:0] ff [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    uart_tx_stim #(.CLK_DIV(DIV)) dut_a (
        .clk(clk), .rst(rst), .data_i(data), .valid_i(valid[0]), .ready_o(ready[0]),
        .uart_tx_o(tx[0]), .busy_o(busy[0]), .byte_done_o(done[0]), .fifo_level_o(lvl[0]));
    uart_tx_stim #(.CLK_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .rst(rst), .data_i(data), .valid_i(valid[1]), .ready_o(ready[1]),
        .uart_tx_o(tx[1]), .busy_o(busy[1]), .byte_done_o(done[1]), .fifo_level_o(lvl[1]));
    uart_tx_stim #(.CLK_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(1)) dut_o (
        .clk(clk), .rst(rst), .data_i(data), .valid_i(valid[2]), .ready_o(ready[2]),
        .uart_tx_o(tx[2]), .busy_o(busy[2]), .byte_done_o(done[2]), .fifo_level_o(lvl[2]));
    uart_tx_stim #(.CLK_DIV(DIV), .STOP_BITS(2)) dut_s (
        .clk(clk), .rst(rst), .data_i(data), .valid_i(valid[3]), .ready_o(ready[3]),
        .uart_tx_o(tx[3]), .busy_o(busy[3]), .byte_done_o(done[3]), .fifo_level_o(lvl[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic push_now(input logic [3:0] m, input logic [7:0] b);
        data  = b;
        valid = m;
        @(posedge clk);
        #1;
        valid = '0;
    endtask

    // Call so that the next rising edge launches the start bit. Each bit segment
    // must hold its value for all DIV cycles; done must pulse once, on the last cycle.
    task automatic check_frame(input int d, input logic [7:0] b, input int par,
                               input int stops, input string tag);
        logic eb[$];
        int   cyc      = 0;
        int   done_cyc = -1;
        int   done_cnt = 0;
        eb.push_back(1'b0);
        for (int i = 0; i < 8; i++) eb.push_back(b[i]);
        if (par >= 0) eb.push_back(par[0]);
        for (int i = 0; i < stops; i++) eb.push_back(1'b1);
        for (int s = 0; s < eb.size(); s++) begin
            logic ok = 1'b1;
            repeat (DIV) begin
                @(posedge clk);
                #1;
                if (tx[d] !== eb[s]) ok = 1'b0;
                if (done[d] === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                cyc++;
            end
            check($sformatf("%s seg%0d", tag, s), ok ? eb[s] : ~eb[s], eb[s]);
        end
        check({tag, " done_cnt"}, done_cnt, 1);
        check({tag, " done_cyc"}, done_cyc, eb.size() * DIV - 1);
    endtask

    initial begin
        rst   = 1'b1;
        valid = '0;
        data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst tx",    tx[0],    1);
        check("rst busy",  busy[0],  0);
        check("rst done",  done[0],  0);
        check("rst level", lvl[0],   0);
        check("rst ready", ready[0], 0);
        rst = 1'b0;
        #1;
        check("ready after rst", ready[0], 1);

        // Single byte: line stays high right after the push edge, start bit follows
        push_now(4'b0001, 8'h65);
        check("single tx at push", tx[0], 1);
        check("single level",      lvl[0], 1);
        check_frame(0, 8'h65, -1, 1, "single");
        @(posedge clk);
        #1;
        check("single idle tx", tx[0],   1);
        check("single idle busy", busy[0], 0);

        // Back-to-back bytes, contiguous frames
        push_now(4'b0001, bb[0]);
        fork
            begin
                for (int k = 1; k < 4; k++) begin
                    data  = bb[k];
                    valid = 4'b0001;
                    @(posedge clk);
                    #1;
                end
                valid = '0;
                check("b2b level", lvl[0], 3);
                check("b2b ready", ready[0], 1);
            end
            begin
                for (int k = 0; k < 4; k++) check_frame(0, bb[k], -1, 1, $sformatf("b2b%0d", k));
            end
        join
        check("b2b busy last", busy[0], 1);
        @(posedge clk);
        #1;
        check("b2b busy drop", busy[0], 0);
        check("b2b idle tx",   tx[0],   1);

        // Full FIFO: sixth byte held off until a pop frees a slot
        push_now(4'b0001, ff[0]);
        fork
            begin
                for (int k = 1; k < 5; k++) begin
                    data  = ff[k];
                    valid = 4'b0001;
                    @(posedge clk);
                    #1;
                end
                check("full ready", ready[0], 0);
                check("full level", lvl[0],   4);
                data  = ff[5];
                valid = 4'b0001;
                repeat (316) @(posedge clk);
                #1;
                check("held level", lvl[0],   4);
                check("held ready", ready[0], 0);
                @(posedge clk);
                #1;
                check("pop level",  lvl[0],   3);
                check("pop ready",  ready[0], 1);
                @(posedge clk);
                #1;
                valid = '0;
                check("refill level", lvl[0],   4);
                check("refill ready", ready[0], 0);
            end
            begin
                for (int k = 0; k < 6; k++) check_frame(0, ff[k], -1, 1, $sformatf("full%0d", k));
            end
        join
        @(posedge clk);
        #1;
        check("full busy drop", busy[0], 0);

        // Parity: even on dut_p, odd on dut_o
        push_now(4'b0110, 8'h07);
        fork
            begin
                data  = 8'h03;
                valid = 4'b0110;
                @(posedge clk);
                #1;
                valid = '0;
            end
            begin
                check_frame(1, 8'h07, 1, 1, "even07");
                check_frame(1, 8'h03, 0, 1, "even03");
            end
            begin
                check_frame(2, 8'h07, 0, 1, "odd07");
                check_frame(2, 8'h03, 1, 1, "odd03");
            end
        join

        // Two stop bits: second start bit begins 352 cycles after the first
        push_now(4'b1000, 8'h81);
        fork
            begin
                data  = 8'h81;
                valid = 4'b1000;
                @(posedge clk);
                #1;
                valid = '0;
            end
            begin
                check_frame(3, 8'h81, -1, 2, "stop2a");
                check_frame(3, 8'h81, -1, 2, "stop2b");
            end
        join
        @(posedge clk);
        #1;
        check("stop2 busy drop", busy[3], 0);

        // Reset during data bit 3 with two bytes queued
        push_now(4'b0001, 8'hA1);
        push_now(4'b0001, 8'hB2);
        push_now(4'b0001, 8'hC3);
        repeat (140) @(posedge clk);
        #1;
        check("pre-rst level", lvl[0], 2);
        check("pre-rst bit3",  tx[0],  0);
        rst = 1'b1;
        #1;
        check("rst ready low", ready[0], 0);
        @(posedge clk);
        #1;
        check("mid rst tx",    tx[0],   1);
        check("mid rst level", lvl[0],  0);
        check("mid rst busy",  busy[0], 0);
        check("mid rst done",  done[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post-rst done", done[0], 0);
        push_now(4'b0001, 8'h3C);
        check_frame(0, 8'h3C, -1, 1, "post_rst");
        @(posedge clk);
        #1;
        check("post_rst busy drop", busy[0], 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
